// File: rtl/ser_add_host.sv
// ser_add_host: parallel host for a bit-serial adder (LSB-first operand stream, serial sum collector).
// Define SER_OVF_EN to add the signed-overflow output ovf.
module ser_add_host #(
  parameter int WIDTH = 4,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_en,
  input  logic             ser_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SER_OVF_EN
  ,output logic            ovf
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, SEND = 2'd1, WAIT = 2'd2, HOLD = 2'd3;
  logic [1:0]    r_state;
  logic [WIDTH:0] r_sa, r_sb, r_col;
  logic [CW-1:0] r_scnt, r_ccnt;
  logic [LAT-1:0] r_dly;
  logic [LAT:0]  w_dly;
  logic          w_den;
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == HOLD;
  assign ser_en    = r_state == SEND;
  assign ser_a     = ser_en & r_sa[0];
  assign ser_b     = ser_en & r_sb[0];
  assign w_dly     = {r_dly, ser_en};
  assign w_den     = r_dly[LAT-1];
  assign sum       = r_col[WIDTH-1:0];
  assign cout      = r_col[WIDTH];
`ifdef SER_OVF_EN
  logic r_am, r_bm;
  assign ovf = (r_am == r_bm) & (r_col[WIDTH-1] != r_am);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_am <= 1'b0;
      r_bm <= 1'b0;
    end else if (in_ready && in_valid) begin
      r_am <= a[WIDTH-1];
      r_bm <= b[WIDTH-1];
    end
  end
`endif
  // The delayed enable aligns capture with the adder's return latency, independent of FSM state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_col   <= '0;
      r_scnt  <= '0;
      r_ccnt  <= '0;
      r_dly   <= '0;
    end else begin
      r_dly <= w_dly[LAT-1:0];
      if (w_den) begin
        r_col  <= {ser_s, r_col[WIDTH:1]};
        r_ccnt <= (r_ccnt == LAST) ? '0 : r_ccnt + 1'b1;
      end
      case (r_state)
        IDLE: if (in_valid) begin
          r_sa    <= {1'b0, a};
          r_sb    <= {1'b0, b};
          r_scnt  <= '0;
          r_state <= SEND;
        end
        SEND: begin
          r_sa    <= r_sa >> 1;
          r_sb    <= r_sb >> 1;
          r_scnt  <= r_scnt + 1'b1;
          r_state <= (r_scnt == LAST) ? WAIT : SEND;
        end
        WAIT: r_state <= (w_den && r_ccnt == LAST) ? HOLD : WAIT;
        default: r_state <= out_ready ? IDLE : HOLD;
      endcase
    end
  end
endmodule

// File: tb/tb_ser_add_host.sv
// tb_ser_add_host: randomized scoreboard bench for ser_add_host with a behavioural serial adder.
module tb_ser_add_host;
  localparam int W = 4;
  localparam int L = 1;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [W-1:0] a = '0, b = '0, sum;
  logic in_ready, ser_a, ser_b, ser_en, ser_s, out_valid, cout;
`ifdef SER_OVF_EN
  logic ovf;
`endif
  int n_chk = 0, n_fail = 0;
  logic [W+1:0] sb[$];
  logic [W+1:0] e;
  logic pv = 1'b0;
  logic [W:0] ps = '0;

  always #5 clk = ~clk;

  ser_add_host #(.WIDTH(W), .LAT(L)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .ser_a(ser_a), .ser_b(ser_b), .ser_en(ser_en), .ser_s(ser_s),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef SER_OVF_EN
    , .ovf(ovf)
`endif
  );

  // External serial adder: gated inputs, one carry flop, L-cycle sum return.
  logic carry = 1'b0;
  logic [L-1:0] pipe = '0;
  logic [L:0] pnext;
  logic ai, bi;
  assign ai = ser_en & ser_a;
  assign bi = ser_en & ser_b;
  assign pnext = {pipe, ai ^ bi ^ carry};
  assign ser_s = pipe[L-1];
  always @(posedge clk) begin
    carry <= (ai & bi) | (ai & carry) | (bi & carry);
    pipe  <= pnext[L-1:0];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W+1:0] model(input int x, input int y);
    int s, sx, sy, ss;
    logic o;
    s  = x + y;
    sx = (x >= 2**(W-1)) ? x - 2**W : x;
    sy = (y >= 2**(W-1)) ? y - 2**W : y;
    ss = sx + sy;
    o  = (ss > 2**(W-1) - 1) || (ss < -(2**(W-1)));
    return {o, (W+1)'(s)};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("ready_valid_excl", {31'd0, in_ready & out_valid}, 0);
      if (out_valid && pv) chk("hold_stable", {27'd0, cout, sum}, {27'd0, ps});
      if (out_valid && out_ready) begin
        chk("sb_nonempty", {31'd0, sb.size() != 0}, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sum", {28'd0, sum}, {28'd0, e[W-1:0]});
          chk("cout", {31'd0, cout}, {31'd0, e[W]});
`ifdef SER_OVF_EN
          chk("ovf", {31'd0, ovf}, {31'd0, e[W+1]});
`endif
        end
      end
      pv = out_valid && !out_ready;
      ps = {cout, sum};
    end else pv = 1'b0;
  end

  task automatic issue(input int x, input int y);
    int k = 0;
    while (!in_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("in_ready_timeout", {31'd0, in_ready}, 1);
    if (in_ready) begin
      in_valid = 1'b1;
      a = W'(x);
      b = W'(y);
      sb.push_back(model(x, y));
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
    end
  endtask

  task automatic check_frame(input int x, input int y);
    for (int n = 1; n <= W + L + 3; n++) begin
      if (n > 1) begin
        @(posedge clk); #1;
      end
      chk("ser_en_win", {31'd0, ser_en}, (n >= 1 && n <= W + 1) ? 1 : 0);
      chk("ser_a_bit", {31'd0, ser_a}, (n <= W + 1) ? (x >> (n - 1)) & 1 : 0);
      chk("ser_b_bit", {31'd0, ser_b}, (n <= W + 1) ? (y >> (n - 1)) & 1 : 0);
      chk("out_valid_time", {31'd0, out_valid}, (n == W + 2 + L) ? 1 : 0);
      chk("in_ready_time", {31'd0, in_ready}, (n == W + 3 + L) ? 1 : 0);
    end
  endtask

  task automatic wait_ready(input bit rnd);
    int k = 0;
    while (!in_ready && k < 200) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      k++;
    end
    out_ready = 1'b1;
    chk("idle_return", {31'd0, in_ready}, 1);
  endtask

  task automatic check_reset_vals();
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_ser_en", {31'd0, ser_en}, 0);
    chk("rst_ser_ab", {30'd0, ser_a, ser_b}, 0);
    chk("rst_sum_cout", {27'd0, cout, sum}, 0);
`ifdef SER_OVF_EN
    chk("rst_ovf", {31'd0, ovf}, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    #1;
    check_reset_vals();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    issue(3, 4);
    check_frame(3, 4);
    issue(9, 8);
    wait_ready(0);
    issue(15, 1);
    check_frame(15, 1);
    out_ready = 1'b0;
    issue(5, 5);
    k = 0;
    while (!out_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (10) begin
      chk("bp_out_valid", {31'd0, out_valid}, 1);
      chk("bp_in_ready", {31'd0, in_ready}, 0);
      chk("bp_result", {27'd0, cout, sum}, 10);
      in_valid = 1'($urandom_range(0, 1));
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_ready(0);
    issue(15, 15);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_reset_vals();
    sb.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    issue(1, 2);
    wait_ready(0);
    issue(7, 1);
    wait_ready(0);
    issue(8, 8);
    wait_ready(0);
    issue(2, 3);
    wait_ready(0);
    repeat (30) begin
      issue(int'($urandom_range(0, 2**W - 1)), int'($urandom_range(0, 2**W - 1)));
      wait_ready(1);
    end
    repeat (3) @(posedge clk);
    #1 chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
